// File: rtl/param_register_file.sv
// Parameterized register file: one write port, two registered read ports sharing
// a read strobe, optional hardwired-zero register 0 and optional write-to-read bypass.

module prf_read_port #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int DEPTH    = 2**ADDR_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ld,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
  input  logic                          wr_act,
  input  logic [ADDR_W-1:0]             wr_adrs,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [ADDR_W-1:0]             adrs,
  output logic [DATA_W-1:0]             q
);
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0] rd_data;

  // Zero-register check comes first so a bypassed write to reg 0 still reads zero.
  always_comb begin
    rd_data = regs[adrs];
    if (ZR && adrs == '0)
      rd_data = '0;
    else if (BP && wr_act && wr_adrs == adrs)
      rd_data = wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset)   q <= '0;
    else if (ld) q <= rd_data;
  end
endmodule

module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_adrs,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] ra_adrs,
  input  logic [ADDR_W-1:0] rb_adrs,
  output logic [DATA_W-1:0] ra_out,
  output logic [DATA_W-1:0] rb_out,
  output logic              out_valid
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int NPORTS = 2;
  localparam int STAGES = 1;
  localparam bit ZR     = (ZERO_REG != 0);

  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [NPORTS-1:0][ADDR_W-1:0] port_adrs;
  logic [NPORTS-1:0][DATA_W-1:0] port_q;
  logic [STAGES:0]               vld_pipe;
  logic                          wr_act;
  logic                          rd_act;

  assign wr_act = enable & wr_en;
  assign rd_act = enable & rd_req;

  always_ff @(posedge clock) begin
    if (reset)
      regs <= '0;
    else if (wr_act && !(ZR && rd_adrs == '0))
      regs[rd_adrs] <= data_in;
  end

  assign port_adrs = {rb_adrs, ra_adrs};

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    prf_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .DEPTH(DEPTH)
    ) u_port (
      .clock  (clock),
      .reset  (reset),
      .ld     (rd_act),
      .regs   (regs),
      .wr_act (wr_act),
      .wr_adrs(rd_adrs),
      .wr_data(data_in),
      .adrs   (port_adrs[p]),
      .q      (port_q[p])
    );
  end

  assign ra_out = port_q[0];
  assign rb_out = port_q[1];

  // Stage 0 is the accepted-read strobe; out_valid is the registered copy.
  assign vld_pipe[0] = rd_act;
  always_ff @(posedge clock) begin
    if (reset) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: three configurations (default, zero-reg/no-bypass,
// 32x16 bypass) driven by shared stimulus and checked against a reference scoreboard.

module tb_param_register_file;
  logic        clock = 1'b0;
  logic        reset, enable, wr_en, rd_req;
  logic [3:0]  wa, ra, rb;
  logic [31:0] din;

  logic [15:0] ra_a, rb_a, ra_b, rb_b;
  logic [31:0] ra_c, rb_c;
  logic        vld_a, vld_b, vld_c;

  typedef struct { logic [31:0] ra; logic [31:0] rb; } exp_t;
  exp_t qa[$], qb[$], qc[$];
  exp_t held_a, held_b, held_c;
  logic [15:0] mem_a [8];
  logic [15:0] mem_b [8];
  logic [31:0] mem_c [16];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .wr_en(wr_en), .rd_adrs(wa[2:0]),
    .data_in(din[15:0]), .rd_req(rd_req), .ra_adrs(ra[2:0]), .rb_adrs(rb[2:0]),
    .ra_out(ra_a), .rb_out(rb_a), .out_valid(vld_a));

  param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .wr_en(wr_en), .rd_adrs(wa[2:0]),
    .data_in(din[15:0]), .rd_req(rd_req), .ra_adrs(ra[2:0]), .rb_adrs(rb[2:0]),
    .ra_out(ra_b), .rb_out(rb_b), .out_valid(vld_b));

  param_register_file #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .wr_en(wr_en), .rd_adrs(wa),
    .data_in(din), .rd_req(rd_req), .ra_adrs(ra), .rb_adrs(rb),
    .ra_out(ra_c), .rb_out(rb_c), .out_valid(vld_c));

  // One clock: predict from current inputs, push expectations, clock, pop and compare.
  task automatic step();
    exp_t ea, eb, ec;
    logic v, r;
    r = reset;
    v = 1'b0;
    if (r) begin
      for (int i = 0; i < 8; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      for (int i = 0; i < 16; i++) mem_c[i] = '0;
    end else begin
      v = enable & rd_req;
      if (v) begin
        ea.ra = {16'h0, (wr_en && wa[2:0] == ra[2:0]) ? din[15:0] : mem_a[ra[2:0]]};
        ea.rb = {16'h0, (wr_en && wa[2:0] == rb[2:0]) ? din[15:0] : mem_a[rb[2:0]]};
        eb.ra = {16'h0, (ra[2:0] == 3'd0) ? 16'h0 : mem_b[ra[2:0]]};
        eb.rb = {16'h0, (rb[2:0] == 3'd0) ? 16'h0 : mem_b[rb[2:0]]};
        ec.ra = (wr_en && wa == ra) ? din : mem_c[ra];
        ec.rb = (wr_en && wa == rb) ? din : mem_c[rb];
        qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
      end
      if (enable && wr_en) begin
        mem_a[wa[2:0]] = din[15:0];
        if (wa[2:0] != 3'd0) mem_b[wa[2:0]] = din[15:0];
        mem_c[wa] = din;
      end
    end
    @(posedge clock); #1;
    total++;
    if (vld_a !== v || vld_b !== v || vld_c !== v) begin
      bad++;
      $display("FAIL out_valid: got a=%b b=%b c=%b want %b", vld_a, vld_b, vld_c, v);
    end
    if (r) begin
      held_a = '{32'h0, 32'h0}; held_b = '{32'h0, 32'h0}; held_c = '{32'h0, 32'h0};
    end else if (v) begin
      if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: empty queue on valid read");
      end else begin
        held_a = qa.pop_front(); held_b = qb.pop_front(); held_c = qc.pop_front();
      end
    end
    total++;
    if (ra_a !== held_a.ra[15:0] || rb_a !== held_a.rb[15:0] ||
        ra_b !== held_b.ra[15:0] || rb_b !== held_b.rb[15:0] ||
        ra_c !== held_c.ra       || rb_c !== held_c.rb) begin
      bad++;
      $display("FAIL read data: got a=%h/%h b=%h/%h c=%h/%h want a=%h/%h b=%h/%h c=%h/%h",
               ra_a, rb_a, ra_b, rb_b, ra_c, rb_c, held_a.ra[15:0], held_a.rb[15:0],
               held_b.ra[15:0], held_b.rb[15:0], held_c.ra, held_c.rb);
    end
  endtask

  task automatic idle();
    reset = 0; enable = 1; wr_en = 0; rd_req = 0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    idle(); wr_en = 1; wa = a; din = d; step();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b);
    idle(); rd_req = 1; ra = a; rb = b; step();
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; wr_en = 1; rd_req = 1; wa = 4'd1; din = 32'h1234_5678;
    ra = 4'd1; rb = 4'd1;
    step(); step();
    idle(); step();
    total++;
    if (ra_a !== 16'h0 || rb_a !== 16'h0 || ra_c !== 32'h0 || vld_a !== 1'b0) begin
      bad++; $display("FAIL reset_state: ra=%h rb=%h rc=%h vld=%b want 0", ra_a, rb_a, ra_c, vld_a);
    end
    do_read(4'd1, 4'd1);
    total++;
    if (ra_a !== 16'h0 || ra_c !== 32'h0) begin
      bad++; $display("FAIL reset_drops_write: ra=%h rc=%h want 0", ra_a, ra_c);
    end
  endtask

  task automatic test_read_after_reset();
    do_read(4'd3, 4'd7);
    total++;
    if (ra_a !== 16'h0 || rb_a !== 16'h0 || vld_a !== 1'b1) begin
      bad++; $display("FAIL read_after_reset: ra=%h rb=%h vld=%b want 0 0 1", ra_a, rb_a, vld_a);
    end
  endtask

  task automatic test_write_read();
    do_write(4'd5, 32'h0000_BEEF);
    do_read(4'd5, 4'd5);
    total++;
    if (ra_a !== 16'hBEEF || rb_a !== 16'hBEEF || vld_a !== 1'b1) begin
      bad++; $display("FAIL write_read: ra=%h rb=%h vld=%b want beef beef 1", ra_a, rb_a, vld_a);
    end
    idle(); step();
    total++;
    if (vld_a !== 1'b0 || ra_a !== 16'hBEEF) begin
      bad++; $display("FAIL valid_pulse: vld=%b ra=%h want 0 beef", vld_a, ra_a);
    end
  endtask

  task automatic test_bypass();
    do_write(4'd2, 32'h0000_1111);
    do_write(4'd4, 32'h0000_0044);
    idle(); wr_en = 1; wa = 4'd2; din = 32'h0000_2222; rd_req = 1; ra = 4'd2; rb = 4'd4;
    step();
    total++;
    if (ra_a !== 16'h2222 || rb_a !== 16'h0044) begin
      bad++; $display("FAIL bypass_on: ra=%h rb=%h want 2222 0044", ra_a, rb_a);
    end
    total++;
    if (ra_b !== 16'h1111 || rb_b !== 16'h0044) begin
      bad++; $display("FAIL bypass_off: ra=%h rb=%h want 1111 0044", ra_b, rb_b);
    end
    do_read(4'd2, 4'd2);
    total++;
    if (ra_b !== 16'h2222) begin
      bad++; $display("FAIL bypass_off_commit: ra=%h want 2222", ra_b);
    end
  endtask

  task automatic test_zero_reg();
    do_write(4'd0, 32'h0000_FFFF);
    do_read(4'd0, 4'd0);
    total++;
    if (ra_b !== 16'h0000 || rb_b !== 16'h0000 || ra_a !== 16'hFFFF) begin
      bad++; $display("FAIL zero_reg: b=%h/%h a=%h want 0000/0000 ffff", ra_b, rb_b, ra_a);
    end
    idle(); wr_en = 1; wa = 4'd0; din = 32'h0000_ABCD; rd_req = 1; ra = 4'd0; rb = 4'd0;
    step();
    total++;
    if (ra_b !== 16'h0000 || ra_a !== 16'hABCD) begin
      bad++; $display("FAIL zero_reg_bypass: b=%h a=%h want 0000 abcd", ra_b, ra_a);
    end
  endtask

  task automatic test_enable_hold();
    do_write(4'd6, 32'h0000_00A5);
    do_read(4'd6, 4'd6);
    for (int i = 0; i < 3; i++) begin
      enable = 0; wr_en = 1; wa = 4'd6; din = 32'h0000_5A5A; rd_req = 1; ra = 4'd6; rb = 4'd6;
      step();
      total++;
      if (ra_a !== 16'h00A5 || vld_a !== 1'b0) begin
        bad++; $display("FAIL enable_hold: ra=%h vld=%b want 00a5 0", ra_a, vld_a);
      end
    end
    do_read(4'd6, 4'd6);
    total++;
    if (ra_a !== 16'h00A5 || ra_c !== 32'h0000_00A5) begin
      bad++; $display("FAIL enable_no_write: ra=%h rc=%h want 00a5", ra_a, ra_c);
    end
  endtask

  task automatic test_wide_reset();
    do_write(4'd15, 32'hDEAD_BEEF);
    do_read(4'd15, 4'd15);
    total++;
    if (ra_c !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL wide_write: rc=%h want deadbeef", ra_c);
    end
    idle(); reset = 1; rd_req = 1; ra = 4'd15; step();
    total++;
    if (ra_c !== 32'h0 || vld_c !== 1'b0) begin
      bad++; $display("FAIL wide_reset: rc=%h vld=%b want 0 0", ra_c, vld_c);
    end
    do_read(4'd15, 4'd14);
    total++;
    if (ra_c !== 32'h0 || rb_c !== 32'h0 || vld_c !== 1'b1) begin
      bad++; $display("FAIL wide_read_after_reset: rc=%h/%h vld=%b want 0/0 1", ra_c, rb_c, vld_c);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      reset  = ($urandom_range(0, 49) == 0);
      enable = ($urandom_range(0, 4) != 0);
      wr_en  = $urandom_range(0, 1);
      rd_req = $urandom_range(0, 1);
      wa  = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      din = $urandom;
      step();
    end
  endtask

  initial begin
    idle(); wa = '0; ra = '0; rb = '0; din = '0;
    held_a = '{32'h0, 32'h0}; held_b = '{32'h0, 32'h0}; held_c = '{32'h0, 32'h0};
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_enable_hold();
    test_wide_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
